// File: rtl/augreal_pkg.sv
// augreal_pkg: shared widths, default frame geometry and packer state encoding.
package augreal_pkg;
  localparam int PIXEL_W         = 18;
  localparam int WORD_W          = 36;
  localparam int DEF_LINE_WORDS  = 640;
  localparam int DEF_FRAME_LINES = 480;
  typedef enum logic [1:0] {IDLE, PACK, PAD, DROP} packer_state_t;
endpackage

// File: rtl/ntsc_pixel_packer.sv
// ntsc_pixel_packer: packs 18-bit NTSC pixels into 36-bit frame-buffer words, normalising every line to LINE_WORDS.
// Optional NTSC_PACKER_FIELD_EN: only a field-0 sof starts a frame; a field-1 sof parks the packer in IDLE.
module ntsc_pixel_packer
  import augreal_pkg::*;
#(
  parameter int LINE_WORDS  = DEF_LINE_WORDS,
  parameter int FRAME_LINES = DEF_FRAME_LINES
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic [PIXEL_W-1:0] in_pixel,
  input  logic               in_sof,
  input  logic               in_eol,
  input  logic               in_field,
  output logic               ntsc_flag,
  output logic [WORD_W-1:0]  ntsc_pixels,
  output logic               frame_flag,
  output logic               overrun
);
  localparam logic [9:0] LW = 10'(LINE_WORDS);
  localparam logic [8:0] FL = 9'(FRAME_LINES);

  packer_state_t      state_q, state_d;
  logic [9:0]         word_cnt_q, word_cnt_d;
  logic [8:0]         line_cnt_q, line_cnt_d;
  logic [PIXEL_W-1:0] pend_q, pend_d;
  logic               pend_vld_q, pend_vld_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic               flag_q, flag_d, frame_q, frame_d, ovr_q, ovr_d;
  logic               sof_go, sof_kill, emit, line_done;
  logic [WORD_W-1:0]  emit_word;

`ifdef NTSC_PACKER_FIELD_EN
  assign sof_go   = in_valid & in_sof & ~in_field;
  assign sof_kill = in_valid & in_sof & in_field;
`else
  logic unused_field;
  assign unused_field = in_field;
  assign sof_go       = in_valid & in_sof;
  assign sof_kill     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      line_cnt_q <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      word_q     <= '0;
      flag_q     <= 1'b0;
      frame_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      line_cnt_q <= line_cnt_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      word_q     <= word_d;
      flag_q     <= flag_d;
      frame_q    <= frame_d;
      ovr_q      <= ovr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    line_cnt_d = line_cnt_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    word_d     = word_q;
    flag_d     = 1'b0;
    frame_d    = 1'b0;
    ovr_d      = ovr_q;
    emit       = 1'b0;
    emit_word  = '0;
    line_done  = 1'b0;
    case (state_q)
      PACK: if (in_valid) begin
        emit       = pend_vld_q | in_eol;
        emit_word  = pend_vld_q ? {pend_q, in_pixel} : {in_pixel, PIXEL_W'(0)};
        pend_d     = in_pixel;
        pend_vld_d = ~pend_vld_q & ~in_eol;
        word_cnt_d = word_cnt_q + 10'(emit);
        if (in_eol) begin
          if (word_cnt_d == LW) line_done = 1'b1;
          else state_d = PAD;
        end else if (word_cnt_d == LW) begin
          state_d = DROP;
        end
      end
      // A pending half left by a 1-pixel sof line goes out as the first pad word.
      PAD: begin
        emit       = 1'b1;
        emit_word  = pend_vld_q ? {pend_q, PIXEL_W'(0)} : '0;
        pend_vld_d = 1'b0;
        ovr_d      = ovr_q | in_valid;
        word_cnt_d = word_cnt_q + 10'd1;
        line_done  = word_cnt_d == LW;
      end
      DROP: line_done = in_valid & in_eol;
      default: ;
    endcase
    if (emit) begin
      flag_d = 1'b1;
      word_d = emit_word;
    end
    if (line_done) begin
      word_cnt_d = '0;
      line_cnt_d = line_cnt_q + 9'd1;
      state_d    = (line_cnt_d == FL) ? IDLE : PACK;
    end
    // A start-of-frame overrides whatever the current state was doing, including a pad word.
    if (sof_go | sof_kill) begin
      flag_d     = 1'b0;
      word_d     = word_q;
      ovr_d      = ovr_q;
      frame_d    = sof_go;
      pend_d     = in_pixel;
      pend_vld_d = sof_go;
      word_cnt_d = '0;
      line_cnt_d = '0;
      state_d    = sof_kill ? IDLE : in_eol ? PAD : PACK;
    end
  end

  assign ntsc_flag   = flag_q;
  assign ntsc_pixels = word_q;
  assign frame_flag  = frame_q;
  assign overrun     = ovr_q;
endmodule

// File: tb/tb_ntsc_pixel_packer.sv
// tb_ntsc_pixel_packer: randomized and directed bench with a line-level word model and an output scoreboard.
module tb_ntsc_pixel_packer;
  localparam int LW = 16;
  localparam int FL = 4;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        in_valid = 1'b0, in_sof = 1'b0, in_eol = 1'b0, in_field = 1'b0;
  logic [17:0] in_pixel = '0;
  logic        ntsc_flag, frame_flag, overrun;
  logic [35:0] ntsc_pixels;
  int          checks = 0, errors = 0, words_seen = 0, frames_seen = 0;
  logic [35:0] exp_q[$];
  logic [35:0] exp_w;

  ntsc_pixel_packer #(.LINE_WORDS(LW), .FRAME_LINES(FL)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_pixel(in_pixel),
    .in_sof(in_sof), .in_eol(in_eol), .in_field(in_field),
    .ntsc_flag(ntsc_flag), .ntsc_pixels(ntsc_pixels), .frame_flag(frame_flag), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_flag) frames_seen++;
    if (ntsc_flag | frame_flag) begin
      checks++;
      if (ntsc_flag & frame_flag) begin
        errors++;
        $display("FAIL flag_overlap: ntsc_flag=1 frame_flag=1, required not both");
      end
    end
    if (ntsc_flag) begin
      words_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL word_extra: got %h, required no word", ntsc_pixels);
      end else begin
        exp_w = exp_q.pop_front();
        if (ntsc_pixels !== exp_w) begin
          errors++;
          $display("FAIL word_value: got %h, required %h", ntsc_pixels, exp_w);
        end
      end
    end
  end

  // A forwarded line: pixel pairs, odd tail half-padded, truncated then zero-filled to LW words.
  function automatic void model_line(input logic [17:0] pix[$]);
    int n = 0, i = 0;
    while (i < pix.size() && n < LW) begin
      exp_q.push_back(i + 1 < pix.size() ? {pix[i], pix[i+1]} : {pix[i], 18'h0});
      i += 2;
      n++;
    end
    while (n < LW) begin
      exp_q.push_back(36'h0);
      n++;
    end
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic px(input logic [17:0] p, input logic s, input logic e);
    in_valid = 1'b1; in_pixel = p; in_sof = s; in_eol = e;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
  endtask

  task automatic send_line(input logic [17:0] pix[$], input logic sof, input int gap);
    for (int i = 0; i < pix.size(); i++) begin
      px(pix[i], sof && i == 0, i == pix.size() - 1);
      if (gap > 0) idle($urandom_range(gap, 0));
    end
    idle(LW + 1);
  endtask

  task automatic test_reset;
    logic [17:0] a, b, c;
    int w0, f0;
    a = 18'($urandom) | 18'h20000; b = 18'($urandom); c = 18'($urandom);
    reset_n = 1'b0;
    idle(2);
    checks += 4;
    if (ntsc_flag !== 1'b0) begin errors++; $display("FAIL reset_ntsc_flag: got %b, required 0", ntsc_flag); end
    if (frame_flag !== 1'b0) begin errors++; $display("FAIL reset_frame_flag: got %b, required 0", frame_flag); end
    if (ntsc_pixels !== 36'h0) begin errors++; $display("FAIL reset_pixels: got %h, required 0", ntsc_pixels); end
    if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b, required 0", overrun); end
    reset_n = 1'b1;
    idle(1);
    exp_q.push_back({a, b});
    px(a, 1'b1, 1'b0);
    px(b, 1'b0, 1'b0);
    checks++;
    if (ntsc_flag !== 1'b1 || ntsc_pixels !== {a, b}) begin
      errors++; $display("FAIL reset_preword: got %b/%h, required 1/%h", ntsc_flag, ntsc_pixels, {a, b});
    end
    px(c, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    checks += 2;
    if ({ntsc_flag, frame_flag, overrun} !== 3'b000) begin
      errors++; $display("FAIL reset_async_flags: got %b%b%b, required 000", ntsc_flag, frame_flag, overrun);
    end
    if (ntsc_pixels !== 36'h0) begin errors++; $display("FAIL reset_async_pixels: got %h, required 0", ntsc_pixels); end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(1);
    w0 = words_seen; f0 = frames_seen;
    px(c ^ 18'h1, 1'b0, 1'b0);
    px(a, 1'b0, 1'b1);
    idle(LW + 2);
    checks += 2;
    if (words_seen != w0 || frames_seen != f0) begin
      errors++; $display("FAIL reset_idle: got %0d words %0d frames, required 0 0", words_seen - w0, frames_seen - f0);
    end
    if (exp_q.size() != 0) begin errors++; $display("FAIL reset_left: %0d words missing, required 0", exp_q.size()); end
  endtask

  task automatic test_basic;
    logic [17:0] q[$];
    int f0;
    q = {18'h00001, 18'h00002, 18'h00003, 18'h00004};
    model_line(q);
    f0 = frames_seen;
    px(18'h00001, 1'b1, 1'b0);
    checks++;
    if (frame_flag !== 1'b1 || ntsc_flag !== 1'b0) begin
      errors++; $display("FAIL basic_frame_flag: got frame=%b word=%b, required 1 0", frame_flag, ntsc_flag);
    end
    px(18'h00002, 1'b0, 1'b0);
    checks++;
    if (ntsc_flag !== 1'b1 || ntsc_pixels !== 36'h000040002) begin
      errors++; $display("FAIL basic_word0: got %b/%h, required 1/000040002", ntsc_flag, ntsc_pixels);
    end
    px(18'h00003, 1'b0, 1'b0);
    checks++;
    if (ntsc_flag !== 1'b0 || frame_flag !== 1'b0) begin
      errors++; $display("FAIL basic_gap: got word=%b frame=%b, required 0 0", ntsc_flag, frame_flag);
    end
    px(18'h00004, 1'b0, 1'b1);
    checks++;
    if (ntsc_flag !== 1'b1 || ntsc_pixels !== 36'h0000C0004) begin
      errors++; $display("FAIL basic_word1: got %b/%h, required 1/0000C0004", ntsc_flag, ntsc_pixels);
    end
    for (int i = 0; i < LW - 2; i++) begin
      idle(1);
      checks++;
      if (ntsc_flag !== 1'b1 || ntsc_pixels !== 36'h0) begin
        errors++; $display("FAIL basic_pad%0d: got %b/%h, required 1/0", i, ntsc_flag, ntsc_pixels);
      end
    end
    idle(1);
    checks += 3;
    if (ntsc_flag !== 1'b0) begin errors++; $display("FAIL basic_pad_end: got %b, required 0", ntsc_flag); end
    if (frames_seen - f0 != 1) begin errors++; $display("FAIL basic_frames: got %0d, required 1", frames_seen - f0); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL basic_left: %0d words missing, required 0", exp_q.size()); end
  endtask

  task automatic test_odd;
    logic [17:0] q[$];
    logic [17:0] a, b, c, p;
    a = 18'($urandom); b = 18'($urandom); c = 18'($urandom) | 18'h1; p = 18'($urandom) | 18'h1;
    q = {a, b, c};
    model_line(q);
    px(a, 1'b0, 1'b0);
    px(b, 1'b0, 1'b0);
    px(c, 1'b0, 1'b1);
    checks++;
    if (ntsc_flag !== 1'b1 || ntsc_pixels !== {c, 18'h0}) begin
      errors++; $display("FAIL odd_tail: got %b/%h, required 1/%h", ntsc_flag, ntsc_pixels, {c, 18'h0});
    end
    idle(LW);
    q = {p};
    model_line(q);
    px(p, 1'b1, 1'b1);
    checks++;
    if (frame_flag !== 1'b1 || ntsc_flag !== 1'b0) begin
      errors++; $display("FAIL odd_sof1_frame: got frame=%b word=%b, required 1 0", frame_flag, ntsc_flag);
    end
    idle(1);
    checks++;
    if (ntsc_flag !== 1'b1 || ntsc_pixels !== {p, 18'h0}) begin
      errors++; $display("FAIL odd_sof1_word: got %b/%h, required 1/%h", ntsc_flag, ntsc_pixels, {p, 18'h0});
    end
    idle(1);
    checks++;
    if (ntsc_flag !== 1'b1 || ntsc_pixels !== 36'h0) begin
      errors++; $display("FAIL odd_sof1_pad: got %b/%h, required 1/0", ntsc_flag, ntsc_pixels);
    end
    idle(LW + 1);
    checks += 2;
    if (ntsc_pixels !== 36'h0) begin errors++; $display("FAIL odd_hold: got %h, required 0", ntsc_pixels); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL odd_left: %0d words missing, required 0", exp_q.size()); end
  endtask

  task automatic test_long;
    logic [17:0] q[$];
    int w0;
    w0 = words_seen;
    for (int i = 0; i < 2 * LW + 8; i++) q.push_back(18'($urandom));
    model_line(q);
    send_line(q, 1'b0, 0);
    checks++;
    if (words_seen - w0 != LW) begin errors++; $display("FAIL long_count: got %0d words, required %0d", words_seen - w0, LW); end
    q.delete();
    for (int i = 0; i < 4; i++) q.push_back(18'($urandom));
    model_line(q);
    send_line(q, 1'b0, 0);
    checks += 2;
    if (overrun !== 1'b0) begin errors++; $display("FAIL long_overrun: got %b, required 0", overrun); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL long_left: %0d words missing, required 0", exp_q.size()); end
  endtask

  task automatic test_restart;
    logic [17:0] q[$];
    logic [17:0] a, b, c, d, e;
    int f0;
    a = 18'($urandom); b = 18'($urandom); c = 18'($urandom); d = 18'($urandom); e = 18'($urandom);
    f0 = frames_seen;
    exp_q.push_back({a, b});
    q = {d, e};
    model_line(q);
    px(a, 1'b1, 1'b0);
    px(b, 1'b0, 1'b0);
    px(c, 1'b0, 1'b0);
    px(d, 1'b1, 1'b0);
    checks++;
    if (frame_flag !== 1'b1 || ntsc_flag !== 1'b0) begin
      errors++; $display("FAIL restart_frame: got frame=%b word=%b, required 1 0", frame_flag, ntsc_flag);
    end
    px(e, 1'b0, 1'b1);
    checks++;
    if (ntsc_flag !== 1'b1 || ntsc_pixels !== {d, e}) begin
      errors++; $display("FAIL restart_word: got %b/%h, required 1/%h", ntsc_flag, ntsc_pixels, {d, e});
    end
    idle(LW + 1);
    checks += 2;
    if (frames_seen - f0 != 2) begin errors++; $display("FAIL restart_frames: got %0d, required 2", frames_seen - f0); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL restart_left: %0d words missing, required 0", exp_q.size()); end
  endtask

  task automatic test_random;
    logic [17:0] q[$];
    int nl, f0;
    f0 = frames_seen;
    for (int f = 0; f < 3; f++) begin
      nl = $urandom_range(FL + 1, 1);
      for (int l = 0; l < nl; l++) begin
        q.delete();
        repeat ($urandom_range(2 * LW + 8, 1)) q.push_back(18'($urandom));
        if (l < FL) model_line(q);
        send_line(q, l == 0, 2);
      end
    end
    checks += 3;
    if (frames_seen - f0 != 3) begin errors++; $display("FAIL random_frames: got %0d, required 3", frames_seen - f0); end
    if (overrun !== 1'b0) begin errors++; $display("FAIL random_overrun: got %b, required 0", overrun); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL random_left: %0d words missing, required 0", exp_q.size()); end
  endtask

  task automatic test_frame_limit;
    logic [17:0] q[$];
    int w0;
    w0 = words_seen;
    q = {18'($urandom), 18'($urandom)};
    model_line(q);
    px(q[0], 1'b1, 1'b0);
    px(q[1], 1'b0, 1'b1);
    idle(2);
    px(18'($urandom), 1'b0, 1'b0);
    idle(1);
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL limit_overrun_set: got %b, required 1", overrun); end
    idle(LW + 1);
    for (int l = 1; l <= FL + 1; l++) begin
      q.delete();
      repeat (2 * LW) q.push_back(18'($urandom));
      if (l < FL) model_line(q);
      send_line(q, 1'b0, 0);
    end
    q = {18'($urandom), 18'($urandom), 18'($urandom)};
    send_line(q, 1'b0, 0);
    checks += 3;
    if (words_seen - w0 != FL * LW) begin
      errors++; $display("FAIL limit_words: got %0d, required %0d", words_seen - w0, FL * LW);
    end
    if (overrun !== 1'b1) begin errors++; $display("FAIL limit_overrun_sticky: got %b, required 1", overrun); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL limit_left: %0d words missing, required 0", exp_q.size()); end
  endtask

`ifdef NTSC_PACKER_FIELD_EN
  task automatic test_field;
    logic [17:0] q[$];
    logic [17:0] a, b;
    int f0, w0;
    a = 18'($urandom); b = 18'($urandom);
    exp_q.push_back({a, b});
    px(a, 1'b1, 1'b0);
    px(b, 1'b0, 1'b0);
    px(18'($urandom), 1'b0, 1'b0);
    f0 = frames_seen; w0 = words_seen;
    in_field = 1'b1;
    px(18'($urandom), 1'b1, 1'b0);
    checks++;
    if (frame_flag !== 1'b0) begin errors++; $display("FAIL field1_frame: got %b, required 0", frame_flag); end
    px(18'($urandom), 1'b0, 1'b0);
    px(18'($urandom), 1'b0, 1'b1);
    idle(LW + 2);
    checks++;
    if (words_seen != w0 || frames_seen != f0) begin
      errors++; $display("FAIL field1_quiet: got %0d words %0d frames, required 0 0", words_seen - w0, frames_seen - f0);
    end
    in_field = 1'b0;
    q = {18'($urandom), 18'($urandom)};
    model_line(q);
    px(q[0], 1'b1, 1'b0);
    checks++;
    if (frame_flag !== 1'b1) begin errors++; $display("FAIL field0_frame: got %b, required 1", frame_flag); end
    px(q[1], 1'b0, 1'b1);
    idle(LW + 1);
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL field_left: %0d words missing, required 0", exp_q.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_odd();
    test_long();
    test_restart();
    test_random();
    test_frame_limit();
`ifdef NTSC_PACKER_FIELD_EN
    test_field();
`endif
    test_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ntsc_pixel_packer.md
# ntsc_pixel_packer

Write-side feeder for the NTSC frame buffer port. It takes the decoded NTSC pixel stream (one 18-bit pixel per strobe) and packs two pixels into each 36-bit word. It emits `ntsc_flag`/`ntsc_pixels` word strobes and a `frame_flag` pulse per frame, exactly as the buffer's write side consumes them. Every line is normalised to a fixed word count so the buffer's 640-word line counter stays aligned.

## Interface
- `LINE_WORDS`, 640: words emitted per line; the buffer wraps at 639.
- `FRAME_LINES`, 480: lines forwarded per frame; later lines are discarded.
- `clk`  in  1: system clock; only clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: `in_pixel` valid this cycle.
- `in_pixel`  in  18: pixel, packed Y[17:12] Cr[11:6] Cb[5:0].
- `in_sof`  in  1: qualified by `in_valid`; this pixel is first of a frame.
- `in_eol`  in  1: qualified by `in_valid`; this pixel is last of its line.
- `in_field`  in  1: field id; used only with `NTSC_PACKER_FIELD_EN`.
- `ntsc_flag`  out  1: one-cycle strobe, `ntsc_pixels` valid.
- `ntsc_pixels`  out  36: word; first pixel of pair in [35:18], second in [17:0].
- `frame_flag`  out  1: one-cycle pulse at frame start.
- `overrun`  out  1: sticky; set when an input pixel is dropped during padding. Cleared only by reset.

## Operation
- States: IDLE, PACK, PAD, DROP.
- IDLE
  - All input is ignored until `in_valid & in_sof`.
  - On that event: pulse `frame_flag`, clear `word_cnt` and `line_cnt`, store the sof pixel as the pending half, and go to PACK.
- PACK
  - A valid pixel with no pending half is stored as the pending half.
  - A valid pixel with a pending half emits `{pending, in_pixel}` and increments `word_cnt`.
- End of line (`in_eol`)
  - An odd pending half is emitted as `{pending, 18'b0}`.
  - If `word_cnt` < `LINE_WORDS` after that, go to PAD.
  - If `word_cnt` == `LINE_WORDS`, the line is done.
- PAD
  - Emit zero words, one per cycle, until `word_cnt` == `LINE_WORDS`.
  - `in_valid` during PAD: the pixel is dropped and `overrun` is set.
- Line completion: once `word_cnt` reaches `LINE_WORDS`, clear `word_cnt` and increment `line_cnt`.
  - If `line_cnt` reaches `FRAME_LINES`, go to IDLE.
  - Otherwise return to PACK.
- Long lines: if `word_cnt` reaches `LINE_WORDS` before `in_eol`, go to DROP. DROP discards pixels through the `in_eol` pixel, then performs line completion.
- `in_sof` in any non-IDLE state restarts the frame:
  - the partial word is discarded, with no padding;
  - `frame_flag` pulses;
  - counters clear;
  - the sof pixel becomes the pending half.
- `word_cnt` is 10 bits and never exceeds `LINE_WORDS`. `line_cnt` is 9 bits.

## Timing
- Reset values: `ntsc_flag`=0, `frame_flag`=0, `ntsc_pixels`=0, `overrun`=0, state IDLE, pending half empty.
- All outputs are registered.
- `frame_flag` is high the cycle after the sof pixel.
- A word strobe is high the cycle after the pixel that completes it. This includes the `in_eol` pixel for a half-padded word.
- PAD words follow back-to-back, starting the cycle after the eol word strobe.
- `frame_flag` and `ntsc_flag` are never high together. If a word would coincide with `frame_flag` (1-pixel line at sof), the word is delayed one cycle.
- `ntsc_pixels` holds its last value when `ntsc_flag` is low.
- Throughput: at most one word per cycle. Upstream must leave at least `LINE_WORDS` − (words in line) idle cycles after `in_eol`.

## Configuration
- `NTSC_PACKER_FIELD_EN` defined:
  - `in_sof` is honoured only when `in_field`=0;
  - an sof with `in_field`=1 sends an active frame to IDLE without `frame_flag`, and all field-1 pixels are ignored.
- `NTSC_PACKER_FIELD_EN` undefined: `in_field` is unused and every sof starts a frame.

## Structure
- Shared package `augreal_pkg`:
  - `PIXEL_W`=18 and `WORD_W`=36;
  - default `LINE_WORDS`/`FRAME_LINES`;
  - state enum `packer_state_t`.
- Single module, no sub-module. The pending-half register and the output register are internal.

## Test plan
- Reset mid-frame (`reset_n` low while in PACK) → all outputs 0, state IDLE; next sof starts cleanly.
- sof pixel 0x00001 then pixels 0x00002, 0x00003, 0x00004, with eol on 0x00004:
  - `frame_flag` at T+1;
  - words 0x000040002 and 0x0000C0004;
  - then 638 zero words back-to-back.
- Odd line of 3 pixels A, B, C (eol on C) → words {A,B} and {C,18'b0}, then 638 pad words.
- 1300-pixel line → exactly 640 words emitted, remaining pixels dropped, next line's words begin at `word_cnt` 0; `overrun` stays 0.
- `in_valid` during PAD → `overrun`=1 and stays 1; 481 full lines → only 480 forwarded, state IDLE after line 480.
- With `NTSC_PACKER_FIELD_EN`: sof with `in_field`=1 → no `frame_flag`, no words; sof with `in_field`=0 → `frame_flag` pulses, packing resumes.
